// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Recovers pixel timing from a VGA-style HS/VS pair. The decoder hunts for
//   horizontal sync and qualifies the line period and sync width. It then
//   waits for a vertical sync edge aligned to column 0. Once locked, it reports
//   the current pixel position, active video, the frame start and any timing
//   violation.
//
// Ports
//   i_clk          system clock
//   i_rst          asynchronous active-high reset
//   i_pixstb       pixel-rate enable; all sampling and state updates use it
//   i_hs, i_vs     horizontal / vertical sync, active low
//   o_x, o_y       recovered column / line (0 while not locked)
//   o_de           active-video flag
//   o_locked       timing lock achieved
//   o_frame_start  one-clock pulse when the locked counters reach (0,0)
//   o_err          one-clock pulse on a timing violation
//   o_err_count    saturating violation count
module vga_sync_decoder #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_TOTAL    = 800,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_TOTAL    = 525,
    parameter int LOCK_LINES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pixstb,
    input  logic       i_hs,
    input  logic       i_vs,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_de,
    output logic       o_locked,
    output logic       o_frame_start,
    output logic       o_err,
    output logic [7:0] o_err_count
);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_PERIOD     = 10'(H_TOTAL);
    localparam logic [9:0] H_WIDTH      = 10'(H_SYNC);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] H_VISIBLE    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VISIBLE    = 10'(V_ACTIVE);
    localparam logic [9:0] CNT_MAX      = 10'd1023;
    localparam logic [7:0] LOCK_COUNT   = 8'(LOCK_LINES);

    // A sync window that does not fit inside its period cannot be decoded.
    if ((H_ACTIVE + H_FP + H_SYNC > H_TOTAL) || (V_ACTIVE + V_FP + V_SYNC > V_TOTAL)) begin : g_timingCheck
        $error("vga_sync_decoder: sync window exceeds total period");
    end

    typedef enum logic [1:0] {SEARCH, H_ALIGN, V_ALIGN, LOCKED} state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic       r_hsPrev;
    logic       r_vsPrev;
    logic [9:0] r_hCount;
    logic [9:0] r_vCount;
    logic [9:0] r_hsLowLen;
    logic [9:0] r_period;
    logic [7:0] r_goodLines;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_de;
    logic       r_locked;
    logic       r_frameStart;
    logic       r_err;
    logic [7:0] r_errCount;

    logic       w_hsFall;
    logic       w_hsRise;
    logic       w_vsFall;
    logic       w_lineGood;
    logic [9:0] w_hInc;
    logic [9:0] w_vInc;
    logic [9:0] w_vAdv;
    logic [9:0] w_hNext;
    logic [9:0] w_vNext;
    logic [9:0] w_periodNext;
    logic [9:0] w_lowLenNext;
    logic [7:0] w_goodInc;
    logic [7:0] w_goodNext;
    logic       w_viol;
    logic       w_locked;

    assign w_hsFall   = r_hsPrev & ~i_hs;
    assign w_hsRise   = ~r_hsPrev & i_hs;
    assign w_vsFall   = r_vsPrev & ~i_vs;

    // hcount/vcount describe the sample taken on this strobe, so the checks
    // below compare against the advanced value rather than the stored one.
    assign w_hInc     = (r_hCount == H_LAST) ? 10'd0 : r_hCount + 10'd1;
    assign w_vInc     = (r_vCount == V_LAST) ? 10'd0 : r_vCount + 10'd1;
    assign w_vAdv     = (r_hCount == H_LAST) ? w_vInc : r_vCount;

    // The period counter restarts at 1 on each HS fall, so it reads exactly
    // H_TOTAL at the next fall. The low-width counter holds its last value
    // through the high phase for the same comparison.
    assign w_lineGood   = (r_period == H_PERIOD) && (r_hsLowLen == H_WIDTH);
    assign w_periodNext = w_hsFall ? 10'd1 :
                          ((r_period == CNT_MAX) ? CNT_MAX : r_period + 10'd1);
    assign w_lowLenNext = w_hsFall ? 10'd1 :
                          ((!i_hs && (r_hsLowLen != CNT_MAX)) ? r_hsLowLen + 10'd1 : r_hsLowLen);
    assign w_goodInc    = r_goodLines + 8'd1;

    // Next-state and next-counter logic. Any violation forces a return to
    // SEARCH with zeroed position counters, except in H_ALIGN. There a bad
    // line restarts qualification from the sync position instead.
    always_comb begin
        w_nextState = r_state;
        w_hNext     = w_hInc;
        w_vNext     = r_vCount;
        w_goodNext  = r_goodLines;
        w_viol      = 1'b0;
        case (r_state)
            SEARCH: begin
                w_hNext = 10'd0;
                w_vNext = 10'd0;
                if (w_hsFall) begin
                    w_hNext     = H_SYNC_START;
                    w_goodNext  = 8'd0;
                    w_nextState = H_ALIGN;
                end
            end
            H_ALIGN: begin
                if (w_hsFall) begin
                    if (w_lineGood) begin
                        w_goodNext = w_goodInc;
                        if (w_goodInc >= LOCK_COUNT) begin
                            w_nextState = V_ALIGN;
                        end
                    end else begin
                        w_goodNext = 8'd0;
                        w_hNext    = H_SYNC_START;
                        w_viol     = 1'b1;
                    end
                end
            end
            V_ALIGN: begin
                if (w_vsFall) begin
                    if (w_hInc == 10'd0) begin
                        w_vNext     = V_SYNC_START;
                        w_nextState = LOCKED;
                    end else begin
                        w_viol      = 1'b1;
                        w_hNext     = 10'd0;
                        w_vNext     = 10'd0;
                        w_nextState = SEARCH;
                    end
                end
            end
            LOCKED: begin
                w_vNext = w_vAdv;
                if (w_hsFall && (w_hInc != H_SYNC_START)) begin
                    w_viol = 1'b1;
                end
                if (w_hsRise && (w_hInc != H_SYNC_END)) begin
                    w_viol = 1'b1;
                end
                if (w_vsFall && ((w_vAdv != V_SYNC_START) || (w_hInc != 10'd0))) begin
                    w_viol = 1'b1;
                end
                if (w_viol) begin
                    w_hNext     = 10'd0;
                    w_vNext     = 10'd0;
                    w_nextState = SEARCH;
                end
            end
            default: begin
                w_hNext     = 10'd0;
                w_vNext     = 10'd0;
                w_nextState = SEARCH;
            end
        endcase
    end

    assign w_locked = (w_nextState == LOCKED);

    // Decoder state register: everything advances only on pixel strobes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= SEARCH;
            r_hsPrev    <= 1'b1;
            r_vsPrev    <= 1'b1;
            r_hCount    <= 10'd0;
            r_vCount    <= 10'd0;
            r_hsLowLen  <= 10'd0;
            r_period    <= 10'd0;
            r_goodLines <= 8'd0;
        end else if (i_pixstb) begin
            r_state     <= w_nextState;
            r_hsPrev    <= i_hs;
            r_vsPrev    <= i_vs;
            r_hCount    <= w_hNext;
            r_vCount    <= w_vNext;
            r_hsLowLen  <= w_lowLenNext;
            r_period    <= w_periodNext;
            r_goodLines <= w_goodNext;
        end
    end

    // Output register. The two pulses are cleared on every clock, so each
    // lasts one i_clk even though strobes are several clocks apart.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x          <= 10'd0;
            r_y          <= 10'd0;
            r_de         <= 1'b0;
            r_locked     <= 1'b0;
            r_frameStart <= 1'b0;
            r_err        <= 1'b0;
            r_errCount   <= 8'd0;
        end else begin
            r_frameStart <= 1'b0;
            r_err        <= 1'b0;
            if (i_pixstb) begin
                r_x          <= w_locked ? w_hNext : 10'd0;
                r_y          <= w_locked ? w_vNext : 10'd0;
                r_de         <= w_locked && (w_hNext < H_VISIBLE) && (w_vNext < V_VISIBLE);
                r_locked     <= w_locked;
                r_frameStart <= w_locked && (w_hNext == 10'd0) && (w_vNext == 10'd0);
                r_err        <= w_viol;
                if (w_viol && (r_errCount != 8'hFF)) begin
                    r_errCount <= r_errCount + 8'd1;
                end
            end
        end
    end

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_de          = r_de;
    assign o_locked      = r_locked;
    assign o_frame_start = r_frameStart;
    assign o_err         = r_err;
    assign o_err_count   = r_errCount;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
//   Bench for vga_sync_decoder with a scaled-down timing so that whole
//   frames fit in a short run. A pattern generator drives HS/VS, and a
//   reference model predicts every output after every clock.
module tb_vga_sync_decoder;

    localparam int H_ACTIVE   = 20;
    localparam int H_FP       = 4;
    localparam int H_SYNC     = 6;
    localparam int H_TOTAL    = 40;
    localparam int V_ACTIVE   = 10;
    localparam int V_FP       = 2;
    localparam int V_SYNC     = 2;
    localparam int V_TOTAL    = 16;
    localparam int LOCK_LINES = 2;
    localparam int H_SS       = H_ACTIVE + H_FP;
    localparam int V_SS       = V_ACTIVE + V_FP;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_pixstb;
    logic       i_hs;
    logic       i_vs;
    logic [9:0] o_x;
    logic [9:0] o_y;
    logic       o_de;
    logic       o_locked;
    logic       o_frame_start;
    logic       o_err;
    logic [7:0] o_err_count;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       locked;
        logic       fs;
        logic       err;
        logic [7:0] cnt;
    } outs_t;

    outs_t expQ[$];
    outs_t mOut;
    int    checks = 0;
    int    passes = 0;
    int    deCount = 0;
    int    fsCount = 0;
    int    errPulses = 0;
    int    gy = 0;

    // Reference model state: 0 SEARCH, 1 H_ALIGN, 2 V_ALIGN, 3 LOCKED
    int    mState, mH, mV, mLow, mPer, mGood, mCnt;
    logic  mHsPrev, mVsPrev;

    always #5 i_clk = ~i_clk;

    vga_sync_decoder #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_TOTAL(H_TOTAL),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_TOTAL(V_TOTAL),
        .LOCK_LINES(LOCK_LINES)
    ) u_dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_pixstb(i_pixstb),
        .i_hs(i_hs),
        .i_vs(i_vs),
        .o_x(o_x),
        .o_y(o_y),
        .o_de(o_de),
        .o_locked(o_locked),
        .o_frame_start(o_frame_start),
        .o_err(o_err),
        .o_err_count(o_err_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mState  = 0;
        mH      = 0;
        mV      = 0;
        mLow    = 0;
        mPer    = 0;
        mGood   = 0;
        mCnt    = 0;
        mHsPrev = 1'b1;
        mVsPrev = 1'b1;
        mOut    = '0;
    endtask

    // One pixel strobe of the timing recovery, written straight from the
    // decoder's behavioural description.
    task automatic modelStrobe(input logic hs, input logic vs);
        bit hf, hr, vf, bad, good;
        int h1, v1, oldPer, oldLow;
        hf = mHsPrev && !hs;
        hr = !mHsPrev && hs;
        vf = mVsPrev && !vs;
        oldPer = mPer;
        oldLow = mLow;
        mPer = hf ? 1 : ((mPer < 1023) ? mPer + 1 : 1023);
        if (hf) mLow = 1;
        else if (!hs) mLow = (mLow < 1023) ? mLow + 1 : 1023;
        mHsPrev = hs;
        mVsPrev = vs;
        h1 = (mH + 1) % H_TOTAL;
        v1 = (h1 == 0) ? (mV + 1) % V_TOTAL : mV;
        bad = 0;
        if (mState == 0) begin
            mH = 0;
            mV = 0;
            if (hf) begin
                mH = H_SS;
                mGood = 0;
                mState = 1;
            end
        end else if (mState == 1) begin
            mH = h1;
            if (hf) begin
                good = (oldPer == H_TOTAL) && (oldLow == H_SYNC);
                if (good) begin
                    mGood++;
                    if (mGood >= LOCK_LINES) mState = 2;
                end else begin
                    mGood = 0;
                    mH = H_SS;
                    bad = 1;
                end
            end
        end else if (mState == 2) begin
            mH = h1;
            if (vf) begin
                if (h1 == 0) begin
                    mV = V_SS;
                    mState = 3;
                end else begin
                    bad = 1;
                    mH = 0;
                    mV = 0;
                    mState = 0;
                end
            end
        end else begin
            if (hf && (h1 != H_SS)) bad = 1;
            if (hr && (h1 != H_SS + H_SYNC)) bad = 1;
            if (vf && ((v1 != V_SS) || (h1 != 0))) bad = 1;
            if (bad) begin
                mState = 0;
                mH = 0;
                mV = 0;
            end else begin
                mH = h1;
                mV = v1;
            end
        end
        if (bad && (mCnt < 255)) mCnt++;
        mOut.locked = (mState == 3);
        mOut.x      = (mState == 3) ? 10'(mH) : 10'd0;
        mOut.y      = (mState == 3) ? 10'(mV) : 10'd0;
        mOut.de     = (mState == 3) && (mH < H_ACTIVE) && (mV < V_ACTIVE);
        mOut.fs     = (mState == 3) && (mH == 0) && (mV == 0);
        mOut.err    = bad;
        mOut.cnt    = 8'(mCnt);
    endtask

    // One i_clk: drive inputs, push the prediction, compare after the edge.
    task automatic tick(input logic stb, input logic hs, input logic vs);
        outs_t expv, obs;
        @(negedge i_clk);
        i_pixstb = stb;
        i_hs = hs;
        i_vs = vs;
        if (i_rst) begin
            modelReset();
        end else if (stb) begin
            modelStrobe(hs, vs);
        end else begin
            mOut.fs = 1'b0;
            mOut.err = 1'b0;
        end
        expQ.push_back(mOut);
        @(posedge i_clk);
        #1;
        obs = {o_x, o_y, o_de, o_locked, o_frame_start, o_err, o_err_count};
        expv = expQ.pop_front();
        checkOutput("outs", obs, expv);
        if (stb && o_de) deCount++;
        if (o_frame_start) fsCount++;
        if (o_err) errPulses++;
    endtask

    // One pixel: a strobe clock followed by an idle clock.
    task automatic applyStimulus(input logic hs, input logic vs);
        tick(1'b1, hs, vs);
        tick(1'b0, hs, vs);
    endtask

    task automatic runSpan(input int xFrom, input int xTo, input int width);
        logic hs, vs;
        for (int x = xFrom; x < xTo; x++) begin
            hs = !((x >= H_SS) && (x < H_SS + width));
            vs = !((gy >= V_SS) && (gy < V_SS + V_SYNC));
            applyStimulus(hs, vs);
        end
    endtask

    task automatic runLine(input int len, input int width);
        runSpan(0, len, width);
        gy = (gy + 1) % V_TOTAL;
    endtask

    task automatic runLines(input int n);
        for (int i = 0; i < n; i++) begin
            runLine(H_TOTAL, H_SYNC);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_pixstb = 1'b0;
        i_hs = 1'b1;
        i_vs = 1'b1;
        modelReset();
        #2;
        checkOutput("resetOuts", {o_x, o_y, o_de, o_locked, o_frame_start, o_err, o_err_count}, 32'h0);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        i_rst = 1'b0;

        // Nominal: lock during frame 1, full frame 2 observed while locked
        gy = 0;
        runLines(V_TOTAL);
        checkOutput("lockedF1", o_locked, 1);
        deCount = 0;
        fsCount = 0;
        errPulses = 0;
        runLines(V_TOTAL);
        checkOutput("deCount", deCount, H_ACTIVE * V_ACTIVE);
        checkOutput("fsCount", fsCount, 1);
        checkOutput("nomErr", errPulses, 0);

        // Short line while locked, relock at the next VS
        errPulses = 0;
        runLines(3);
        runLine(H_TOTAL - 1, H_SYNC);
        runLines(1);
        checkOutput("shortUnlock", o_locked, 0);
        runLines(V_TOTAL - 5);
        checkOutput("shortErrPulses", errPulses, 1);
        checkOutput("shortErrCount", o_err_count, 8'd1);
        checkOutput("shortRelock", o_locked, 1);

        // HS one strobe too narrow while locked
        errPulses = 0;
        runLines(5);
        runLine(H_TOTAL, H_SYNC - 1);
        checkOutput("narrowUnlock", o_locked, 0);
        runLines(V_TOTAL - 6);
        checkOutput("narrowErrPulses", errPulses, 1);
        checkOutput("narrowErrCount", o_err_count, 8'd2);
        checkOutput("narrowRelock", o_locked, 1);

        // Asynchronous reset in the middle of the frame
        runLines(7);
        runSpan(0, 15, H_SYNC);
        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        checkOutput("rstAsync", {o_x, o_y, o_de, o_locked, o_frame_start, o_err, o_err_count}, 32'h0);
        modelReset();
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        i_rst = 1'b0;
        runSpan(15, H_TOTAL, H_SYNC);
        gy = (gy + 1) % V_TOTAL;
        runLines(4);
        checkOutput("relockPending", o_locked, 0);
        runLines(1);
        checkOutput("relockDone", o_locked, 1);
        runLines(3);

        // Stalled strobe
        errPulses = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1'b0, 1'b1, 1'b1);
        end
        checkOutput("stallErr", errPulses, 0);
        checkOutput("stallLocked", o_locked, 1);

        // Saturation: a 4-strobe HS period is a violation on nearly every fall
        errPulses = 0;
        for (int i = 0; i < 310; i++) begin
            applyStimulus(1'b1, 1'b1);
            applyStimulus(1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1);
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("satCount", o_err_count, 8'hFF);
        checkOutput("satPulses", (errPulses >= 300), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL expose parameters: H_ACTIVE 640 visible pixels; H_FP 16 front porch; H_SYNC 96 sync width; H_TOTAL 800 pixels per line; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_TOTAL 525; LOCK_LINES 2 good lines needed before vertical search.
REQ-002 SHALL have port: i_clk  in  1  system clock (100 MHz).
REQ-003 SHALL have port: i_rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: i_pixstb  in  1  pixel-rate enable (25 MHz, one i_clk wide).
REQ-005 SHALL have port: i_hs  in  1  horizontal sync, active low.
REQ-006 SHALL have port: i_vs  in  1  vertical sync, active low.
REQ-007 SHALL have port: o_x  out  10  recovered pixel column.
REQ-008 SHALL have port: o_y  out  10  recovered line number.
REQ-009 SHALL have port: o_de  out  1  active-video flag.
REQ-010 SHALL have port: o_locked  out  1  timing lock achieved.
REQ-011 SHALL have port: o_frame_start  out  1  one-i_clk pulse at pixel (0,0).
REQ-012 SHALL have port: o_err  out  1  one-i_clk pulse on a timing violation.
REQ-013 SHALL have port: o_err_count  out  8  saturating violation count.

Function
REQ-014 SHALL sample i_hs and i_vs only on i_clk edges where i_pixstb=1; all state SHALL advance only on those edges.
REQ-015 SHALL detect an HS falling edge as previous sample 1 and current sample 0; VS falling edge likewise.
REQ-016 SHALL keep hcount (0..H_TOTAL-1), hs_low_len and a line-period counter, each incremented per strobe.
REQ-017 SHALL use FSM states SEARCH, H_ALIGN, V_ALIGN and LOCKED.
REQ-018 SEARCH: on the first HS falling edge, load hcount=H_ACTIVE+H_FP (656), clear good-line count, and go to H_ALIGN.
REQ-019 H_ALIGN: on each HS falling edge, the line is good if period=H_TOTAL and the previous low width=H_SYNC; increment good-line count when good, otherwise clear it and reload hcount=656.
REQ-020 H_ALIGN SHALL go to V_ALIGN when good-line count reaches LOCK_LINES.
REQ-021 V_ALIGN: on a VS falling edge, load vcount=V_ACTIVE+V_FP (490) and enter LOCKED; hcount SHALL already be 0 at that strobe, else treat it as a violation and return to SEARCH.
REQ-022 LOCKED: hcount wraps H_TOTAL-1 to 0; vcount increments on that wrap and wraps V_TOTAL-1 to 0.
REQ-023 LOCKED: an HS falling edge with hcount≠656, an HS rising edge with hcount≠752, or a VS falling edge with (vcount,hcount)≠(490,0) SHALL pulse o_err, increment o_err_count (saturating at 255) and return to SEARCH.
REQ-024 Violations detected in H_ALIGN or V_ALIGN SHALL pulse o_err and increment o_err_count.
REQ-025 An HS edge and a VS edge on the same strobe SHALL both be evaluated; one violation SHALL give one o_err pulse and one count increment.
REQ-026 Outputs SHALL be registered and update on the i_clk edge after the qualifying strobe (latency 1 i_clk).
REQ-027 o_x/o_y SHALL equal hcount/vcount when o_locked=1 and SHALL be 0 otherwise.
REQ-028 o_de SHALL be 1 iff locked, hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-029 o_locked SHALL be 1 iff state=LOCKED.
REQ-030 o_frame_start SHALL pulse for exactly one i_clk when LOCKED counters reach (0,0).
REQ-031 An unqualified period counter SHALL saturate at 1023 without wrapping.

Reset
REQ-032 i_rst=1 SHALL immediately force state=SEARCH, all counters 0, stored sync samples 1, o_x=0, o_y=0, o_de=0, o_locked=0, o_frame_start=0, o_err=0, o_err_count=0.
REQ-033 Reset asserted mid-frame SHALL discard lock; relock after release SHALL require the full SEARCH→LOCKED sequence.

Verification
REQ-034 Nominal: drive the standard 640x480 sync pattern from reset. o_locked rises at the first VS fall after 2 good lines; the first o_frame_start follows 35 lines later, and o_de is high for exactly 640x480 strobes per frame.
REQ-035 Short line: one HS period of 799 while locked. Expect one o_err pulse, o_err_count=1, o_locked=0, then relock at the next VS.
REQ-036 Wrong sync width: HS low for 95 strobes while locked. The rising edge at hcount=751 gives o_err and returns to SEARCH.
REQ-037 Saturation: inject 300 violations. o_err_count holds at 255.
REQ-038 Reset mid-frame at (x=300, y=200). All outputs reach their reset values with no i_clk edge needed; after release, relock takes 2 lines plus a VS edge.
REQ-039 Stalled strobe: hold i_pixstb=0 for 1000 i_clk. No counter or output changes, and no o_err pulse.
